// File: rtl/gpu_cmd_queue.sv
// Command FIFO and one-at-a-time issue sequencer between the CPU and the rasterizer.
// Optional frame-synchronised fence entries are enabled by defining GPU_CMD_QUEUE_FENCE_EN.

package common;
    typedef enum logic [2:0] {
        RC_NOP   = 3'd0,
        RC_PIXEL = 3'd1,
        RC_LINE  = 3'd2,
        RC_RECT  = 3'd3,
        RC_FILL  = 3'd4,
        RC_CLEAR = 3'd5
    } raster_command_t;
endpackage

module gpu_cmd_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CW    = $bits(common::raster_command_t)
) (
    input  logic                    clk,
    input  logic                    rst_async,
`ifdef GPU_CMD_QUEUE_FENCE_EN
    input  logic                    push_fence,
    input  logic                    frame_start,
`endif
    input  logic                    push,
    input  logic [CW-1:0]           cmd_in,
    input  logic [7:0]              x0_in,
    input  logic [7:0]              y0_in,
    input  logic [7:0]              x1_in,
    input  logic [7:0]              y1_in,
    input  logic [2:0]              colour_in,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    idle,
    output logic [CW-1:0]           gpu_command,
    output logic [7:0]              gpu_x0,
    output logic [7:0]              gpu_y0,
    output logic [7:0]              gpu_x1,
    output logic [7:0]              gpu_y1,
    output logic [2:0]              gpu_colour,
    output logic                    gpu_execute_request,
    input  logic                    gpu_busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned NW = AW + 1;

    typedef struct packed {
`ifdef GPU_CMD_QUEUE_FENCE_EN
        logic          fence;
`endif
        logic [CW-1:0] cmd;
        logic [7:0]    x0;
        logic [7:0]    y0;
        logic [7:0]    x1;
        logic [7:0]    y1;
        logic [2:0]    colour;
    } entry_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_SETTLE = 3'd2,
`ifdef GPU_CMD_QUEUE_FENCE_EN
        S_FENCE  = 3'd4,
`endif
        S_WAIT   = 3'd3
    } state_t;

    state_t        state;
    entry_t        mem [DEPTH];
    entry_t        wr_entry;
    entry_t        head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [NW-1:0] count_nxt;
    logic          push_ok;
    logic          pop;

    assign push_ok = push && !full;
    assign pop     = (state == S_IDLE) && !empty;
    assign head    = mem[rd_ptr];
    assign idle    = (state == S_IDLE) && empty;

    always_comb begin
        wr_entry        = '0;
`ifdef GPU_CMD_QUEUE_FENCE_EN
        wr_entry.fence  = push_fence;
`endif
        wr_entry.cmd    = cmd_in;
        wr_entry.x0     = x0_in;
        wr_entry.y0     = y0_in;
        wr_entry.x1     = x1_in;
        wr_entry.y1     = y1_in;
        wr_entry.colour = colour_in;
    end

    // Occupancy after this edge; a push and a pop together leave it unchanged.
    always_comb begin
        count_nxt = count;
        if (push_ok && !pop) begin
            count_nxt = count + NW'(1);
        end else if (!push_ok && pop) begin
            count_nxt = count - NW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && full) begin
                overflow <= 1'b1;
            end
            count <= count_nxt;
            full  <= (count_nxt == NW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state               <= S_IDLE;
            gpu_execute_request <= 1'b0;
            gpu_command         <= '0;
            gpu_x0              <= '0;
            gpu_y0              <= '0;
            gpu_x1              <= '0;
            gpu_y1              <= '0;
            gpu_colour          <= '0;
        end else begin
            gpu_execute_request <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
`ifdef GPU_CMD_QUEUE_FENCE_EN
                        if (head.fence) begin
                            state <= S_FENCE;
                        end else
`endif
                        begin
                            gpu_command         <= head.cmd;
                            gpu_x0              <= head.x0;
                            gpu_y0              <= head.y0;
                            gpu_x1              <= head.x1;
                            gpu_y1              <= head.y1;
                            gpu_colour          <= head.colour;
                            gpu_execute_request <= 1'b1;
                            state               <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE:  state <= S_SETTLE;
                // Busy is not trusted yet: the rasterizer is still raising it.
                S_SETTLE: state <= S_WAIT;
                S_WAIT: begin
                    if (!gpu_busy) begin
                        state <= S_IDLE;
                    end
                end
`ifdef GPU_CMD_QUEUE_FENCE_EN
                S_FENCE: begin
                    if (frame_start) begin
                        state <= S_IDLE;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
